// File: rtl/mdr_seq_pkg.sv
// Shared types and constants for the memory sequencer.
package mdr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LOAD   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic ID_FETCH = 1'b0;
  localparam logic ID_DATA  = 1'b1;

endpackage

// File: rtl/mdr_mem_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time wins.
module rr_arb2
  import mdr_seq_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  // Pick the winner and raise its one-hot grant only while arbitration is enabled
  always_comb begin
    grant    = '0;
    grant_id = (&valid) ? ~last_grant : valid[ID_DATA];
    if (enable && (|valid)) begin
      grant[grant_id] = 1'b1;
    end
  end

endmodule

// File: rtl/mdr_mem_sequencer.sv
// Memory transaction sequencer: arbitrates fetch/data requesters onto one memory
// port and drives the MDR load and bus enables.
// Optional build macro MEM_TIMEOUT_EN adds an ACCESS timeout that aborts with rsp_err.
module mdr_mem_sequencer
  import mdr_seq_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              mdr_load_en,
  output logic              mdr_bus_en
);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_d;
  logic [1:0]        grant;
  logic              grant_id;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
`endif

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .enable     ((state_q == IDLE) && !rst),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign req0_ready = grant[ID_FETCH];
  assign req1_ready = grant[ID_DATA];
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rsp_id     = id_q;

  // Next-state and latched-field computation
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    id_d         = id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
`ifdef MEM_TIMEOUT_EN
    err_d        = err_q;
    cnt_d        = cnt_q;
`else
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d      = ACCESS;
          last_grant_d = grant_id;
          id_d         = grant_id;
          we_d         = grant_id & req1_we;
          addr_d       = grant_id ? req1_addr : req0_addr;
          wdata_d      = grant_id ? req1_wdata : '0;
`ifdef MEM_TIMEOUT_EN
          err_d        = 1'b0;
          cnt_d        = '0;
`endif
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = we_q ? RESP : LOAD;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      LOAD:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched transaction fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      id_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef MEM_TIMEOUT_EN
      err_q        <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
`ifdef MEM_TIMEOUT_EN
      err_q        <= err_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Strobes and enables are flops fed from the next state so MDR sees clean edges
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mdr_load_en <= 1'b0;
      mdr_bus_en  <= 1'b0;
      rsp_valid   <= 1'b0;
    end else begin
      mem_rd      <= (state_d == ACCESS) && !we_d;
      mem_wr      <= (state_d == ACCESS) && we_d;
      mdr_load_en <= (state_d == LOAD);
      mdr_bus_en  <= (state_d == RESP) && !we_d && !err_d;
      rsp_valid   <= (state_d == RESP);
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Abort flag reported alongside the completion pulse
  always_ff @(posedge clk) begin
    if (rst) rsp_err <= 1'b0;
    else     rsp_err <= (state_d == RESP) && err_d;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_mem_sequencer.sv
// Directed self-checking bench for mdr_mem_sequencer.
module tb_mdr_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic [15:0] req0_addr;
  logic        req0_ready;
  logic        req1_valid;
  logic        req1_we;
  logic [15:0] req1_addr;
  logic [15:0] req1_wdata;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic        rsp_err;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        mdr_load_en;
  logic        mdr_bus_en;

  int unsigned num_checks = 0;
  int unsigned num_errors = 0;

  mdr_mem_sequencer #(
    .ADDR_W         (16),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_ready  (req1_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_err     (rsp_err),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mdr_load_en (mdr_load_en),
    .mdr_bus_en  (mdr_bus_en)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards change before the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after input changes
  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req0_valid = 1'b1; req0_addr = 16'h0; req1_valid = 1'b1;
    req1_we = 1'b0; req1_addr = 16'h0; req1_wdata = 16'h0; mem_ack = 1'b0;
    tick(); tick();
    settle();
    check_eq("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check_eq("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check_eq("rst_strobes", {28'd0, mem_rd, mem_wr, mdr_load_en, mdr_bus_en}, 32'd0);
    check_eq("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check_eq("rst_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Fetch read with immediate ack
    req0_valid = 1'b1; req0_addr = 16'h0040;
    settle();
    check_eq("rd_ready0", {31'd0, req0_ready}, 32'd1);
    check_eq("rd_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; mem_ack = 1'b1;
    settle();
    check_eq("rd_acc_rd", {30'd0, mem_rd, mem_wr}, 32'd2);
    check_eq("rd_acc_addr", {16'd0, mem_addr}, 32'h0040);
    check_eq("rd_acc_load", {31'd0, mdr_load_en}, 32'd0);
    tick();
    mem_ack = 1'b0;
    settle();
    check_eq("rd_load", {28'd0, mdr_load_en, mem_rd, mdr_bus_en, rsp_valid}, 32'h8);
    tick();
    settle();
    check_eq("rd_resp", {27'd0, rsp_valid, rsp_id, mdr_bus_en, rsp_err, mdr_load_en}, 32'h14);
    tick();
    req0_valid = 1'b1;
    settle();
    check_eq("rd_next_ready", {31'd0, req0_ready}, 32'd1);
    check_eq("rd_idle_rsp", {30'd0, rsp_valid, mdr_bus_en}, 32'd0);
    req0_valid = 1'b0;
    settle();

    // Data write, ack on the third ACCESS cycle
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 16'h1234; req1_wdata = 16'hBEEF;
    settle();
    check_eq("wr_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 16'h0; req1_wdata = 16'h0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2);
      settle();
      check_eq($sformatf("wr_acc%0d_strb", i), {28'd0, mem_rd, mem_wr, mdr_load_en, mdr_bus_en}, 32'h4);
      check_eq($sformatf("wr_acc%0d_addr", i), {16'd0, mem_addr}, 32'h1234);
      check_eq($sformatf("wr_acc%0d_data", i), {16'd0, mem_wdata}, 32'hBEEF);
      check_eq($sformatf("wr_acc%0d_rsp", i), {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    mem_ack = 1'b0;
    settle();
    check_eq("wr_resp", {26'd0, rsp_valid, rsp_id, rsp_err, mem_wr, mdr_load_en, mdr_bus_en}, 32'h30);
    tick();
    settle();
    check_eq("wr_after", {29'd0, rsp_valid, mdr_load_en, mdr_bus_en}, 32'd0);

    // Round-robin from a fresh reset: contention grants 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 16'h0100; req1_addr = 16'h0200;
      settle();
      check_eq($sformatf("rr%0d_grant", i), {30'd0, req1_ready, req0_ready},
               (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      settle();
      check_eq($sformatf("rr%0d_addr", i), {16'd0, mem_addr}, (i % 2 == 0) ? 32'h0100 : 32'h0200);
      tick(); tick();
      settle();
      check_eq($sformatf("rr%0d_rsp", i), {30'd0, rsp_valid, rsp_id}, (i % 2 == 0) ? 32'd2 : 32'd3);
      tick();
    end
    // Lone requester is granted every time
    for (int i = 0; i < 4; i++) begin
      req0_valid = (i < 2); req1_valid = (i >= 2);
      settle();
      check_eq($sformatf("solo%0d_grant", i), {30'd0, req1_ready, req0_ready},
               (i < 2) ? 32'd1 : 32'd2);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(); tick();
      settle();
      check_eq($sformatf("solo%0d_rsp", i), {30'd0, rsp_valid, rsp_id}, (i < 2) ? 32'd2 : 32'd3);
      tick();
    end
    mem_ack = 1'b0;

    // Reset during ACCESS of a read drops the transaction
    req0_valid = 1'b1; req0_addr = 16'h0077;
    tick();
    req0_valid = 1'b0;
    settle();
    check_eq("rstmid_rd", {31'd0, mem_rd}, 32'd1);
    rst = 1'b1; req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'h0099;
    settle();
    check_eq("rstmid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    rst = 1'b0; mem_ack = 1'b1;
    settle();
    check_eq("rstmid_idle", {27'd0, mem_rd, mem_wr, mdr_load_en, mdr_bus_en, rsp_valid}, 32'd0);
    check_eq("rstmid_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("rstmid_accept", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    settle();
    check_eq("rstmid_new_rd", {16'd0, mem_addr}, 32'h0099);
    check_eq("rstmid_new_strb", {30'd0, mem_rd, mdr_load_en}, 32'd2);
    tick(); tick();
    mem_ack = 1'b0;
    settle();
    check_eq("rstmid_new_rsp", {29'd0, rsp_valid, rsp_id, mdr_bus_en}, 32'd7);
    tick();

`ifdef MEM_TIMEOUT_EN
    // Ack never arrives: abort after 4 ACCESS cycles
    req0_valid = 1'b1; req0_addr = 16'h0500;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq($sformatf("to%0d_acc", i), {29'd0, mem_rd, mdr_load_en, rsp_valid}, 32'd4);
      tick();
    end
    settle();
    check_eq("to_resp", {27'd0, rsp_valid, rsp_err, mdr_bus_en, mdr_load_en, mem_rd}, 32'h18);
    tick();
    // Ack on the 4th cycle still succeeds
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      settle();
      check_eq($sformatf("tok%0d_acc", i), {30'd0, mem_rd, rsp_valid}, 32'd2);
      tick();
    end
    mem_ack = 1'b0;
    settle();
    check_eq("tok_load", {31'd0, mdr_load_en}, 32'd1);
    tick();
    settle();
    check_eq("tok_resp", {29'd0, rsp_valid, rsp_err, mdr_bus_en}, 32'd5);
    tick();
`else
    // Without the timeout the read waits indefinitely
    req0_valid = 1'b1; req0_addr = 16'h0500;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    settle();
    check_eq("wait_acc", {28'd0, mem_rd, rsp_valid, rsp_err, mdr_load_en}, 32'h8);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    settle();
    check_eq("wait_resp", {29'd0, rsp_valid, rsp_err, mdr_bus_en}, 32'd5);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
